ex_issue_stage: RTL and testbench

- ID/EX pipeline register and execute-stage issue logic. It drives the operand, control-code and shift-amount inputs of the execute ALU.
- Decodes ALU op and funct into the ALU's 4-bit control code, applies EX/MEM and MEM/WB forwarding, and handles stall and flush.
- Consumes the ALU's zero and overflow flags: gates register write-back and raises a one-shot overflow trap with the faulting PC.

---
 rtl/ex_issue_if.sv | 59 +++++
 rtl/ex_issue_stage.sv | 155 +++++++++++++++
 tb/tb_ex_issue_stage.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ex_issue_if.sv
// ex_issue_if: ID/EX issue bundle between decode, forwarding sources and the execute ALU
interface ex_issue_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              id_valid;
    logic [XLEN-1:0]   id_pc;
    logic [XLEN-1:0]   id_rs_val;
    logic [XLEN-1:0]   id_rt_val;
    logic [XLEN-1:0]   id_imm;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic [4:0]        id_shamt;
    logic [5:0]        id_funct;
    logic [2:0]        id_alu_op;
    logic              id_use_imm;
    logic              id_reg_write;
    logic              id_trap_en;
    logic              stall;
    logic              flush;
    logic              mem_reg_write;
    logic [REG_AW-1:0] mem_rd;
    logic [XLEN-1:0]   mem_result;
    logic              wb_reg_write;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_result;
    logic              alu_zero;
    logic              alu_overflow;
    logic [XLEN-1:0]   alu_data1;
    logic [XLEN-1:0]   alu_data2;
    logic [3:0]        alu_ctrl;
    logic [4:0]        alu_shamt;
    logic              ex_valid;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_reg_write;
    logic              ex_zero;
    logic              illegal_op;
    logic              ovf_trap;
    logic [XLEN-1:0]   epc;

    modport master (
        output id_valid, id_pc, id_rs_val, id_rt_val, id_imm, id_rs, id_rt, id_rd,
               id_shamt, id_funct, id_alu_op, id_use_imm, id_reg_write, id_trap_en,
               stall, flush, mem_reg_write, mem_rd, mem_result,
               wb_reg_write, wb_rd, wb_result, alu_zero, alu_overflow,
        input  alu_data1, alu_data2, alu_ctrl, alu_shamt, ex_valid, ex_rd,
               ex_reg_write, ex_zero, illegal_op, ovf_trap, epc
    );

    modport slave (
        input  id_valid, id_pc, id_rs_val, id_rt_val, id_imm, id_rs, id_rt, id_rd,
               id_shamt, id_funct, id_alu_op, id_use_imm, id_reg_write, id_trap_en,
               stall, flush, mem_reg_write, mem_rd, mem_result,
               wb_reg_write, wb_rd, wb_result, alu_zero, alu_overflow,
        output alu_data1, alu_data2, alu_ctrl, alu_shamt, ex_valid, ex_rd,
               ex_reg_write, ex_zero, illegal_op, ovf_trap, epc
    );
endinterface

// File: rtl/ex_issue_stage.sv
// ex_issue_stage: ID/EX register, ALU control decode, operand forwarding and overflow trap
module ex_issue_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input logic       clk,
    input logic       rst,
    ex_issue_if.slave bus
);
    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SLL = 4'b0011;
    localparam logic [3:0] C_SRL = 4'b0101;
    localparam logic [3:0] C_SUB = 4'b0110;
    localparam logic [3:0] C_SLT = 4'b0111;
    localparam logic [3:0] C_NOR = 4'b1100;
    localparam logic [3:0] C_BAD = 4'b1111;

    logic              v;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs_val;
    logic [XLEN-1:0]   rt_val;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [2:0]        alu_op;
    logic              use_imm;
    logic              reg_write;
    logic              trap_en;
    logic              trap_done;
    logic              ovf_trap;
    logic [XLEN-1:0]   epc;

    logic [3:0]        rctrl;
    logic [3:0]        ctrl;
    logic [XLEN-1:0]   fwd_rs;
    logic [XLEN-1:0]   fwd_rt;
    logic              illegal;
    logic              arith_ovf;
    logic              trap_fire;

    // ID/EX pipeline register: flush kills, stall holds (and remembers a fired trap), otherwise load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v         <= 1'b0;
            pc        <= '0;
            rs_val    <= '0;
            rt_val    <= '0;
            imm       <= '0;
            rs        <= '0;
            rt        <= '0;
            rd        <= '0;
            shamt     <= '0;
            funct     <= '0;
            alu_op    <= '0;
            use_imm   <= 1'b0;
            reg_write <= 1'b0;
            trap_en   <= 1'b0;
            trap_done <= 1'b0;
        end else if (bus.flush) begin
            v         <= 1'b0;
            trap_done <= 1'b0;
        end else if (!bus.stall) begin
            v         <= bus.id_valid;
            pc        <= bus.id_pc;
            rs_val    <= bus.id_rs_val;
            rt_val    <= bus.id_rt_val;
            imm       <= bus.id_imm;
            rs        <= bus.id_rs;
            rt        <= bus.id_rt;
            rd        <= bus.id_rd;
            shamt     <= bus.id_shamt;
            funct     <= bus.id_funct;
            alu_op    <= bus.id_alu_op;
            use_imm   <= bus.id_use_imm;
            reg_write <= bus.id_reg_write;
            trap_en   <= bus.id_trap_en;
            trap_done <= 1'b0;
        end else begin
            trap_done <= trap_done | trap_fire;
        end
    end

    // Overflow trap: one-cycle pulse after the overflowing EX cycle, epc latches the faulting PC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_trap <= 1'b0;
            epc      <= '0;
        end else begin
            ovf_trap <= trap_fire;
            if (trap_fire) epc <= pc;
        end
    end

    // R-type funct decode into the ALU control code
    always_comb begin
        rctrl = C_BAD;
        case (funct)
            6'b100000: rctrl = C_ADD;
            6'b100010: rctrl = C_SUB;
            6'b100100: rctrl = C_AND;
            6'b100101: rctrl = C_OR;
            6'b100111: rctrl = C_NOR;
            6'b101010: rctrl = C_SLT;
            6'b000000: rctrl = C_SLL;
            6'b000010: rctrl = C_SRL;
            default:   rctrl = C_BAD;
        endcase
    end

    // ALU op class decode; R-type defers to funct, unused classes are illegal
    always_comb begin
        ctrl = alu_op == 3'b000 ? C_ADD :
               alu_op == 3'b001 ? C_SUB :
               alu_op == 3'b010 ? rctrl :
               alu_op == 3'b011 ? C_AND :
               alu_op == 3'b100 ? C_OR  :
               alu_op == 3'b101 ? C_SLT : C_BAD;
    end

    // Operand forwarding: EX/MEM beats MEM/WB, r0 always reads the registered value
    always_comb begin
        fwd_rs = (rs != '0 && bus.mem_reg_write && bus.mem_rd == rs) ? bus.mem_result :
                 (rs != '0 && bus.wb_reg_write && bus.wb_rd == rs)   ? bus.wb_result  : rs_val;
        fwd_rt = (rt != '0 && bus.mem_reg_write && bus.mem_rd == rt) ? bus.mem_result :
                 (rt != '0 && bus.wb_reg_write && bus.wb_rd == rt)   ? bus.wb_result  : rt_val;
    end

    // Operand routing: sll shifts data1 so it takes rt; srl takes rt as data2 regardless of use_imm
    always_comb begin
        bus.alu_data1 = ctrl == C_SLL ? fwd_rt : fwd_rs;
        bus.alu_data2 = (ctrl == C_SLL || ctrl == C_SRL) ? fwd_rt : use_imm ? imm : fwd_rt;
    end

    // Write-back gating and trap qualification from the ALU flags
    always_comb begin
        illegal   = ctrl == C_BAD;
        arith_ovf = trap_en & bus.alu_overflow & (ctrl == C_ADD || ctrl == C_SUB);
        trap_fire = v & arith_ovf & ~trap_done & ~bus.flush;
    end

    assign bus.alu_ctrl     = ctrl;
    assign bus.alu_shamt    = shamt;
    assign bus.ex_valid     = v;
    assign bus.ex_rd        = rd;
    assign bus.ex_reg_write = v & reg_write & ~illegal & ~arith_ovf;
    assign bus.ex_zero      = v & bus.alu_zero;
    assign bus.illegal_op   = v & illegal;
    assign bus.ovf_trap     = ovf_trap;
    assign bus.epc          = epc;
endmodule

// File: tb/tb_ex_issue_stage.sv
// tb_ex_issue_stage: scoreboard bench for the ID/EX issue stage
module tb_ex_issue_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ex_issue_if #(.XLEN(32), .REG_AW(5)) b();
    ex_issue_stage #(.XLEN(32), .REG_AW(5)) dut (.clk(clk), .rst(rst), .bus(b));

    typedef struct packed {
        logic        v;
        logic [3:0]  ctrl;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  sh;
        logic        ill;
        logic        rw;
        logic        zero;
        logic [4:0]  rd;
    } exp_t;

    typedef struct packed {
        logic [2:0] op;
        logic [5:0] fn;
        logic [3:0] ctrl;
    } dec_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic v, input logic [3:0] ctrl, input logic [31:0] d1, d2,
                                input logic [4:0] sh, input logic ill, rw, zero, input logic [4:0] rd);
        return '{v: v, ctrl: ctrl, d1: d1, d2: d2, sh: sh, ill: ill, rw: rw, zero: zero, rd: rd};
    endfunction

    task automatic drive(input logic [2:0] op, input logic [5:0] fn, input logic [4:0] rs, rt, rd,
                         input logic [31:0] rsv, rtv, imm, input logic ui, tr,
                         input logic [4:0] sh, input logic [31:0] pc);
        b.id_valid     = 1'b1;
        b.id_alu_op    = op;
        b.id_funct     = fn;
        b.id_rs        = rs;
        b.id_rt        = rt;
        b.id_rd        = rd;
        b.id_rs_val    = rsv;
        b.id_rt_val    = rtv;
        b.id_imm       = imm;
        b.id_use_imm   = ui;
        b.id_trap_en   = tr;
        b.id_reg_write = 1'b1;
        b.id_shamt     = sh;
        b.id_pc        = pc;
    endtask

    task automatic check_ex();
        exp_t e;
        chk("sb_size", 64'(sbq.size()), 64'd1);
        if (sbq.size() == 0) return;
        e = sbq.pop_front();
        chk("valid", b.ex_valid, e.v);
        chk("ctrl", b.alu_ctrl, e.ctrl);
        chk("data1", b.alu_data1, e.d1);
        chk("data2", b.alu_data2, e.d2);
        chk("shamt", b.alu_shamt, e.sh);
        chk("illegal", b.illegal_op, e.ill);
        chk("reg_write", b.ex_reg_write, e.rw);
        chk("zero", b.ex_zero, e.zero);
        chk("rd", b.ex_rd, e.rd);
    endtask

    task automatic issue(input exp_t e);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        b.id_valid = 1'b0;
        check_ex();
    endtask

    dec_t tbl[14] = '{
        '{3'b000, 6'h00, 4'b0010}, '{3'b001, 6'h00, 4'b0110}, '{3'b011, 6'h00, 4'b0000},
        '{3'b100, 6'h00, 4'b0001}, '{3'b101, 6'h00, 4'b0111}, '{3'b010, 6'h20, 4'b0010},
        '{3'b010, 6'h22, 4'b0110}, '{3'b010, 6'h24, 4'b0000}, '{3'b010, 6'h25, 4'b0001},
        '{3'b010, 6'h27, 4'b1100}, '{3'b010, 6'h2A, 4'b0111}, '{3'b110, 6'h20, 4'b1111},
        '{3'b111, 6'h20, 4'b1111}, '{3'b010, 6'h3F, 4'b1111}
    };

    initial begin
        int pulses;
        b.id_valid = 0; b.id_pc = 0; b.id_rs_val = 0; b.id_rt_val = 0; b.id_imm = 0;
        b.id_rs = 0; b.id_rt = 0; b.id_rd = 0; b.id_shamt = 0; b.id_funct = 0;
        b.id_alu_op = 0; b.id_use_imm = 0; b.id_reg_write = 0; b.id_trap_en = 0;
        b.stall = 0; b.flush = 0;
        b.mem_reg_write = 0; b.mem_rd = 0; b.mem_result = 0;
        b.wb_reg_write = 0; b.wb_rd = 0; b.wb_result = 0;
        b.alu_zero = 0; b.alu_overflow = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", b.ex_valid, 0);
        chk("rst_ovf", b.ovf_trap, 0);
        chk("rst_epc", b.epc, 0);
        chk("rst_ctrl", b.alu_ctrl, 4'b0010);
        chk("rst_d1", b.alu_data1, 0);
        chk("rst_d2", b.alu_data2, 0);
        chk("rst_rd", b.ex_rd, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        drive(3'b000, 6'h00, 5'd1, 5'd2, 5'd3, 32'h7FFFFFFF, 32'h1, 32'h0, 1'b0, 1'b1, 5'd0, 32'h100);
        b.alu_overflow = 1'b1;
        issue(mk(1, 4'b0010, 32'h7FFFFFFF, 32'h1, 5'd0, 0, 0, 0, 5'd3));
        chk("ovf_early", b.ovf_trap, 0);
        @(posedge clk);
        #1;
        b.alu_overflow = 1'b0;
        chk("ovf_pulse", b.ovf_trap, 1);
        chk("ovf_epc", b.epc, 32'h100);
        @(posedge clk);
        #1;
        chk("ovf_one_shot", b.ovf_trap, 0);
        chk("epc_hold", b.epc, 32'h100);

        drive(3'b000, 6'h00, 5'd1, 5'd2, 5'd4, 32'h7FFFFFFF, 32'h1, 32'h0, 1'b0, 1'b1, 5'd0, 32'h200);
        b.alu_overflow = 1'b1;
        issue(mk(1, 4'b0010, 32'h7FFFFFFF, 32'h1, 5'd0, 0, 0, 0, 5'd4));
        b.stall = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            pulses += int'(b.ovf_trap);
            chk("stall_ctrl", b.alu_ctrl, 4'b0010);
        end
        chk("stall_pulses", 64'(pulses), 64'd1);
        chk("stall_epc", b.epc, 32'h200);
        b.stall = 1'b0;
        b.alu_overflow = 1'b0;
        @(posedge clk);
        #1;
        chk("stall_release_ovf", b.ovf_trap, 0);

        drive(3'b010, 6'h00, 5'd6, 5'd5, 5'd7, 32'h99, 32'h3, 32'h0, 1'b0, 1'b0, 5'd4, 32'h300);
        issue(mk(1, 4'b0011, 32'h3, 32'h3, 5'd4, 0, 1, 0, 5'd7));
        drive(3'b010, 6'h02, 5'd6, 5'd5, 5'd7, 32'h40, 32'h3, 32'h77, 1'b1, 1'b0, 5'd2, 32'h304);
        issue(mk(1, 4'b0101, 32'h40, 32'h3, 5'd2, 0, 1, 0, 5'd7));

        b.mem_reg_write = 1; b.mem_rd = 5'd8; b.mem_result = 32'hAA;
        b.wb_reg_write = 1;  b.wb_rd = 5'd8;  b.wb_result = 32'hBB;
        b.alu_zero = 1'b1;
        drive(3'b000, 6'h00, 5'd8, 5'd2, 5'd1, 32'h11, 32'h0, 32'h5, 1'b1, 1'b0, 5'd0, 32'h400);
        issue(mk(1, 4'b0010, 32'hAA, 32'h5, 5'd0, 0, 1, 1, 5'd1));
        b.alu_zero = 1'b0;
        b.mem_rd = 5'd9;
        drive(3'b000, 6'h00, 5'd8, 5'd2, 5'd1, 32'h11, 32'h0, 32'h5, 1'b1, 1'b0, 5'd0, 32'h404);
        issue(mk(1, 4'b0010, 32'hBB, 32'h5, 5'd0, 0, 1, 0, 5'd1));
        b.mem_rd = 5'd0; b.wb_rd = 5'd0;
        drive(3'b000, 6'h00, 5'd0, 5'd0, 5'd1, 32'h22, 32'h33, 32'h5, 1'b0, 1'b0, 5'd0, 32'h408);
        issue(mk(1, 4'b0010, 32'h22, 32'h33, 5'd0, 0, 1, 0, 5'd1));
        b.mem_rd = 5'd7; b.mem_result = 32'hCC;
        drive(3'b001, 6'h00, 5'd3, 5'd7, 5'd2, 32'h1, 32'h2, 32'h9, 1'b0, 1'b0, 5'd0, 32'h40C);
        issue(mk(1, 4'b0110, 32'h1, 32'hCC, 5'd0, 0, 1, 0, 5'd2));
        b.mem_reg_write = 0; b.wb_reg_write = 0;

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].op, tbl[i].fn, 5'd1, 5'd2, 5'd9, 32'h1000 + i, 32'h2000 + i, 32'h0,
                  1'b0, 1'b0, 5'd0, 32'h500);
            issue(mk(1, tbl[i].ctrl, 32'h1000 + i, 32'h2000 + i, 5'd0,
                     tbl[i].ctrl == 4'b1111, tbl[i].ctrl != 4'b1111, 0, 5'd9));
        end

        drive(3'b000, 6'h00, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 32'h0, 1'b0, 1'b0, 5'd0, 32'h600);
        issue(mk(1, 4'b0010, 32'h5, 32'h6, 5'd0, 0, 1, 0, 5'd3));
        b.stall = 1'b1;
        b.flush = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_stall_valid", b.ex_valid, 0);
        b.stall = 1'b0;
        b.flush = 1'b0;

        drive(3'b001, 6'h00, 5'd1, 5'd2, 5'd3, 32'h80000000, 32'h1, 32'h0, 1'b0, 1'b1, 5'd0, 32'h700);
        b.alu_overflow = 1'b1;
        issue(mk(1, 4'b0110, 32'h80000000, 32'h1, 5'd0, 0, 0, 0, 5'd3));
        b.flush = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_no_trap", b.ovf_trap, 0);
        chk("flush_valid", b.ex_valid, 0);
        b.flush = 1'b0;

        drive(3'b000, 6'h00, 5'd1, 5'd2, 5'd3, 32'h7FFFFFFF, 32'h1, 32'h0, 1'b0, 1'b1, 5'd0, 32'h800);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("pre_rst_valid", b.ex_valid, 1);
        chk("pre_rst_ovf", b.ovf_trap, 1);
        chk("pre_rst_epc", b.epc, 32'h800);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", b.ex_valid, 0);
        chk("arst_ovf", b.ovf_trap, 0);
        chk("arst_epc", b.epc, 0);
        chk("arst_ctrl", b.alu_ctrl, 4'b0010);
        b.id_valid = 1'b0;
        b.alu_overflow = 1'b0;
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_ovf", b.ovf_trap, 0);
        chk("sb_drained", 64'(sbq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
